// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, default datapath sizes and
// the operand stack FSM state type. Also used by the control unit.
package cpu_pkg;

  localparam int DATA_RANGE_DEF = 8;
  localparam int DEPTH_DEF      = 16;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_PUSH = 3'b001,
    OP_POP  = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_AND  = 3'b101,
    OP_OR   = 3'b110,
    OP_DUP  = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  // True for the two-operand opcodes that go through the ALU
  function automatic logic is_alu_op(op_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational two-operand ALU for the operand stack.
// Computes R = B op A, where A is the old top and B the entry below it.
module stack_alu
  import cpu_pkg::*;
#(
  parameter int W = DATA_RANGE_DEF
) (
  input  op_e          op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         carry,
  output logic         zero
);

  logic [W:0] wide;

  // One extra bit captures the ADD carry-out or the SUB borrow (A > B)
  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = {1'b0, b} + {1'b0, a};
      OP_SUB:  wide = {1'b0, b} - {1'b0, a};
      OP_AND:  wide = {1'b0, b & a};
      OP_OR:   wide = {1'b0, b | a};
      default: wide = '0;
    endcase
  end

  assign result = wide[W-1:0];
  assign carry  = wide[W];
  assign zero   = (wide[W-1:0] == '0);

endmodule

// File: rtl/operand_stack.sv
// Operand stack for the CPU datapath: storage, stack pointer and the
// IDLE/EXEC command FSM. Two-operand operations take one extra cycle.
module operand_stack
  import cpu_pkg::*;
#(
  parameter int DATA_RANGE = DATA_RANGE_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [DATA_RANGE-1:0] cmd_data,
  output logic                  done,
  output logic                  err,
  output logic [DATA_RANGE-1:0] pop_data,
  output logic [DATA_RANGE-1:0] top,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output logic                  carry,
  output logic                  zero
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_RANGE-1:0] mem [DEPTH];

  state_e                state;
  op_e                   cmd_opcode;
  op_e                   op_q;
  logic [DATA_RANGE-1:0] op_a;
  logic [DATA_RANGE-1:0] op_b;

  logic                  accept;
  logic                  reject;
  logic [PTR_W-1:0]      wr_idx;
  logic [PTR_W-1:0]      top_idx;
  logic [PTR_W-1:0]      sec_idx;

  logic                  mem_we;
  logic [PTR_W-1:0]      mem_addr;
  logic [DATA_RANGE-1:0] mem_wdata;

  logic [DATA_RANGE-1:0] alu_result;
  logic                  alu_carry;
  logic                  alu_zero;

  assign cmd_opcode = op_e'(cmd_op);
  assign cmd_ready  = (state == ST_IDLE);
  assign accept     = cmd_valid && cmd_ready;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign wr_idx  = PTR_W'(count);
  assign top_idx = PTR_W'(count - CNT_W'(1));
  assign sec_idx = PTR_W'(count - CNT_W'(2));
  assign top     = empty ? '0 : mem[top_idx];

  stack_alu #(
    .W(DATA_RANGE)
  ) u_alu (
    .op    (op_q),
    .a     (op_a),
    .b     (op_b),
    .result(alu_result),
    .carry (alu_carry),
    .zero  (alu_zero)
  );

  // Decide whether the presented command would overflow or underflow the stack
  always_comb begin
    reject = 1'b0;
    case (cmd_opcode)
      OP_PUSH:                     reject = full;
      OP_POP:                      reject = empty;
      OP_DUP:                      reject = empty || full;
      OP_ADD, OP_SUB, OP_AND, OP_OR: reject = (count < CNT_W'(2));
      default:                     reject = 1'b0;
    endcase
  end

  // Select the single storage write for this cycle: ALU result in EXEC, else PUSH/DUP
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = wr_idx;
    mem_wdata = cmd_data;
    if (state == ST_EXEC) begin
      mem_we    = 1'b1;
      mem_addr  = sec_idx;
      mem_wdata = alu_result;
    end else if (accept && !reject) begin
      if (cmd_opcode == OP_PUSH) begin
        mem_we = 1'b1;
      end else if (cmd_opcode == OP_DUP) begin
        mem_we    = 1'b1;
        mem_wdata = top;
      end
    end
  end

  // Entry storage is deliberately left unreset; count alone defines validity
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Command FSM with registered done/err, stack pointer, flags and pop result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      count    <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      pop_data <= '0;
      op_q     <= OP_NOP;
      op_a     <= '0;
      op_b     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (reject) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else if (is_alu_op(cmd_opcode)) begin
              op_q  <= cmd_opcode;
              op_a  <= top;
              op_b  <= mem[sec_idx];
              state <= ST_EXEC;
            end else begin
              done <= 1'b1;
              case (cmd_opcode)
                OP_PUSH, OP_DUP: count <= count + CNT_W'(1);
                OP_POP: begin
                  count    <= count - CNT_W'(1);
                  pop_data <= top;
                end
                default: ;
              endcase
            end
          end
        end
        ST_EXEC: begin
          count <= count - CNT_W'(1);
          carry <= alu_carry;
          zero  <= alu_zero;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_operand_stack.sv
// Directed self-checking bench for operand_stack with hand-computed expectations.
module tb_operand_stack;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [7:0] cmd_data;
  logic       done;
  logic       err;
  logic [7:0] pop_data;
  logic [7:0] top;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       carry;
  logic       zero;

  int checks = 0;
  int errors = 0;

  operand_stack dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .done     (done),
    .err      (err),
    .pop_data (pop_data),
    .top      (top),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .carry    (carry),
    .zero     (zero)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Guard against a stuck run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Present one command for exactly one cycle; returns at the following falling edge
  task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = OP_PUSH;
    cmd_data  = 8'h5A;
  endtask

  // Spend the EXEC cycle with a bogus command offered, which must be ignored
  task automatic execCycle();
    cmd_valid = 1'b1;
    cmd_op    = OP_PUSH;
    cmd_data  = 8'h99;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    cmd_data  = 8'h00;

    // Reset state
    #1;
    checkOutput("rst_count", count, 0);
    checkOutput("rst_empty", empty, 1);
    checkOutput("rst_full", full, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_carry", carry, 0);
    checkOutput("rst_zero", zero, 0);
    checkOutput("rst_pop", pop_data, 0);
    checkOutput("rst_top", top, 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("rel_ready", cmd_ready, 1);

    // PUSH 05, PUSH 03, SUB -> 02
    applyStimulus(OP_PUSH, 8'h05);
    checkOutput("p1_done", done, 1);
    checkOutput("p1_err", err, 0);
    checkOutput("p1_count", count, 1);
    checkOutput("p1_top", top, 8'h05);
    applyStimulus(OP_PUSH, 8'h03);
    checkOutput("p2_top", top, 8'h03);
    applyStimulus(OP_SUB, 8'h00);
    checkOutput("sub_wait_done", done, 0);
    checkOutput("sub_wait_ready", cmd_ready, 0);
    execCycle();
    checkOutput("sub_done", done, 1);
    checkOutput("sub_err", err, 0);
    checkOutput("sub_top", top, 8'h02);
    checkOutput("sub_count", count, 1);
    checkOutput("sub_carry", carry, 0);
    checkOutput("sub_zero", zero, 0);
    checkOutput("sub_ready", cmd_ready, 1);
    @(negedge clk);
    checkOutput("sub_done_pulse", done, 0);
    checkOutput("exec_ignored_count", count, 1);

    // Borrow case then ADD wrapping to zero
    applyReset();
    applyStimulus(OP_PUSH, 8'h03);
    applyStimulus(OP_PUSH, 8'h05);
    applyStimulus(OP_SUB, 8'h00);
    execCycle();
    checkOutput("borrow_top", top, 8'hFE);
    checkOutput("borrow_carry", carry, 1);
    checkOutput("borrow_zero", zero, 0);
    checkOutput("borrow_count", count, 1);
    applyStimulus(OP_PUSH, 8'h02);
    applyStimulus(OP_ADD, 8'h00);
    checkOutput("add_wait_done", done, 0);
    execCycle();
    checkOutput("add_done", done, 1);
    checkOutput("add_top", top, 8'h00);
    checkOutput("add_carry", carry, 1);
    checkOutput("add_zero", zero, 1);
    checkOutput("add_count", count, 1);

    // ADD with a single entry is rejected immediately, flags untouched
    applyStimulus(OP_ADD, 8'h00);
    checkOutput("rej_add_done", done, 1);
    checkOutput("rej_add_err", err, 1);
    checkOutput("rej_add_ready", cmd_ready, 1);
    checkOutput("rej_add_carry", carry, 1);
    checkOutput("rej_add_zero", zero, 1);
    checkOutput("rej_add_count", count, 1);

    // POP on empty, then PUSH/DUP/POP and the logic operations
    applyReset();
    applyStimulus(OP_POP, 8'h00);
    checkOutput("pop_empty_done", done, 1);
    checkOutput("pop_empty_err", err, 1);
    checkOutput("pop_empty_count", count, 0);
    checkOutput("pop_empty_data", pop_data, 0);
    applyStimulus(OP_PUSH, 8'h7F);
    applyStimulus(OP_DUP, 8'h00);
    checkOutput("dup_err", err, 0);
    checkOutput("dup_count", count, 2);
    checkOutput("dup_top", top, 8'h7F);
    applyStimulus(OP_POP, 8'h00);
    checkOutput("pop_done", done, 1);
    checkOutput("pop_err", err, 0);
    checkOutput("pop_data", pop_data, 8'h7F);
    checkOutput("pop_count", count, 1);
    applyStimulus(OP_NOP, 8'h00);
    checkOutput("nop_done", done, 1);
    checkOutput("nop_count", count, 1);
    applyStimulus(OP_PUSH, 8'h0F);
    applyStimulus(OP_AND, 8'h00);
    execCycle();
    checkOutput("and_top", top, 8'h0F);
    checkOutput("and_carry", carry, 0);
    checkOutput("and_zero", zero, 0);
    applyStimulus(OP_PUSH, 8'hF0);
    applyStimulus(OP_OR, 8'h00);
    execCycle();
    checkOutput("or_top", top, 8'hFF);
    checkOutput("or_count", count, 1);
    applyStimulus(OP_PUSH, 8'h00);
    applyStimulus(OP_AND, 8'h00);
    execCycle();
    checkOutput("and0_top", top, 8'h00);
    checkOutput("and0_zero", zero, 1);
    checkOutput("and0_carry", carry, 0);
    checkOutput("pop_hold", pop_data, 8'h7F);

    // Fill to capacity, then overflow attempts
    applyReset();
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(OP_PUSH, 8'(i));
    end
    checkOutput("fill_count", count, 16);
    checkOutput("fill_full", full, 1);
    checkOutput("fill_top", top, 8'h10);
    applyStimulus(OP_PUSH, 8'hAA);
    checkOutput("ovf_err", err, 1);
    checkOutput("ovf_full", full, 1);
    checkOutput("ovf_count", count, 16);
    checkOutput("ovf_top", top, 8'h10);
    applyStimulus(OP_DUP, 8'h00);
    checkOutput("dup_full_err", err, 1);
    checkOutput("dup_full_count", count, 16);
    applyStimulus(OP_POP, 8'h00);
    checkOutput("drain_pop", pop_data, 8'h10);
    checkOutput("drain_count", count, 15);
    checkOutput("drain_full", full, 0);
    checkOutput("drain_top", top, 8'h0F);

    // Reset while an ADD is executing aborts it
    applyReset();
    applyStimulus(OP_PUSH, 8'h01);
    applyStimulus(OP_PUSH, 8'h02);
    applyStimulus(OP_ADD, 8'h00);
    checkOutput("abort_in_exec", cmd_ready, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_count", count, 0);
    checkOutput("abort_ready", cmd_ready, 1);
    @(negedge clk);
    checkOutput("abort_done_rst", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("abort_done_after", done, 0);
    checkOutput("abort_count_after", count, 0);
    checkOutput("abort_ready_after", cmd_ready, 1);
    checkOutput("abort_top_after", top, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
